// File: rtl/timer_pkg.sv
// Shared types and constants for the timer datapath (state encoding, BCD digit type).
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam bcd_t BCD_NINE     = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;

    function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/countdown_mmss_bcd_digit_down.sv
// Single BCD down-counting digit with synchronous clear/load and borrow output.
module bcd_digit_down
    import timer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic [3:0] wrap,
    input  logic       dec_en,
    output logic [3:0] digit,
    output logic       borrow_out
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= '0;
        end else if (clr) begin
            digit <= '0;
        end else if (load) begin
            digit <= load_val;
        end else if (dec_en) begin
            digit <= (digit == '0) ? wrap : digit - 4'd1;
        end
    end

    assign borrow_out = (digit == '0) && dec_en;

endmodule

// File: rtl/countdown_mmss.sv
// Loadable BCD MM:SS countdown timer with one-cycle done pulse.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to reload the last loaded value on reaching zero.
module countdown_mmss
    import timer_pkg::*;
#(
    parameter int unsigned MM_MAX = 59
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       load,
    input  logic [3:0] load_m1,
    input  logic [3:0] load_m0,
    input  logic [3:0] load_s1,
    input  logic [3:0] load_s0,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic       running,
    output logic       done
);

    localparam bcd_t MM_MAX_T = 4'(MM_MAX / 10);
    localparam bcd_t MM_MAX_U = 4'(MM_MAX % 10);

    state_t      state, state_d;
    logic        running_d, done_d;
    bcd_t        cl_m1, cl_m0, cl_s1, cl_s0;
    logic [15:0] load_word, reload_word, digit_val;
    logic        load_ok, tick_en, reach_zero, reload, digit_ld;
    logic        count_zero, count_one;
    logic        s0_borrow, s1_borrow, m0_borrow, m1_borrow;

    always_comb begin
        cl_m1 = clamp_digit(load_m1, BCD_NINE);
        cl_m0 = clamp_digit(load_m0, BCD_NINE);
        cl_s1 = clamp_digit(load_s1, SEC_TENS_MAX);
        cl_s0 = clamp_digit(load_s0, BCD_NINE);
        if ((32'(cl_m1) * 32'd10 + 32'(cl_m0)) > MM_MAX) begin
            cl_m1 = MM_MAX_T;
            cl_m0 = MM_MAX_U;
        end
    end

    assign load_word  = {cl_m1, cl_m0, cl_s1, cl_s0};
    assign load_ok    = load && !clear && (state != RUN);
    assign count_zero = ({m1, m0, s1, s0} == 16'h0000);
    assign count_one  = ({m1, m0, s1, s0} == 16'h0001);
    assign tick_en    = (state == RUN) && tick && !pause && !clear;
    assign reach_zero = tick_en && count_one;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [15:0] shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow <= '0;
        end else if (clear) begin
            shadow <= '0;
        end else if (load_ok) begin
            shadow <= load_word;
        end
    end

    assign reload      = reach_zero && (shadow != '0);
    assign reload_word = shadow;
`else
    assign reload      = 1'b0;
    assign reload_word = '0;
`endif

    // load_ok and reload are exclusive: one needs RUN, the other forbids it
    assign digit_ld  = load_ok || reload;
    assign digit_val = reload ? reload_word : load_word;

    bcd_digit_down u_s0 (
        .clk(clk), .rst_n(rst_n), .clr(clear), .load(digit_ld), .load_val(digit_val[3:0]),
        .wrap(BCD_NINE), .dec_en(tick_en), .digit(s0), .borrow_out(s0_borrow)
    );
    bcd_digit_down u_s1 (
        .clk(clk), .rst_n(rst_n), .clr(clear), .load(digit_ld), .load_val(digit_val[7:4]),
        .wrap(SEC_TENS_MAX), .dec_en(s0_borrow), .digit(s1), .borrow_out(s1_borrow)
    );
    bcd_digit_down u_m0 (
        .clk(clk), .rst_n(rst_n), .clr(clear), .load(digit_ld), .load_val(digit_val[11:8]),
        .wrap(BCD_NINE), .dec_en(s1_borrow), .digit(m0), .borrow_out(m0_borrow)
    );
    bcd_digit_down u_m1 (
        .clk(clk), .rst_n(rst_n), .clr(clear), .load(digit_ld), .load_val(digit_val[15:12]),
        .wrap(BCD_NINE), .dec_en(m0_borrow), .digit(m1), .borrow_out(m1_borrow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        if (clear || load_ok) begin
            state_d = IDLE;
        end else begin
            unique case (state)
                IDLE, PAUSE: if (start && !count_zero) state_d = RUN;
                // m1 borrow means an underflow past 00:00; treat it as finished
                RUN: begin
                    if (pause) state_d = PAUSE;
                    else if ((reach_zero && !reload) || m1_borrow) state_d = DONE;
                end
                DONE: state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        running_d = (state_d == RUN);
        done_d    = reach_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            running <= running_d;
            done    <= done_d;
        end
    end

endmodule
